// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one combinational barrel shifter among NREQ requesters.
// Latency: accept edge E0, rsp_valid high after E1; earliest next accept at E3 (no overlap).
// Backpressure: rsp_valid/rsp_data/rsp_id hold until rsp_ready; req_ready stays 0 meanwhile.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester handshake (req_ready one-hot or zero)
//   req_data/shift/mode       packed per-requester operands (i at [i*W +: W])
//   sh_data/sh_shift/sh_mode  operands to the external shifter, held from operand regs
//   sh_out                    combinational shifter result
//   rsp_valid/ready/data/id   single response port tagged with requester index
//   busy                      high whenever the FSM is not idle
module barrel_shift_arbiter #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ),
  localparam int SW  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_data,
  input  logic [NREQ*SW-1:0] req_shift,
  input  logic [NREQ*2-1:0] req_mode,
  output logic [N-1:0]      sh_data,
  output logic [SW-1:0]     sh_shift,
  output logic [1:0]        sh_mode,
  input  logic [N-1:0]      sh_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr_nxt;
  logic           grant_vld;
  logic           accept;
  logic [IDW:0]   cand_sum;
  logic [IDW:0]   ptr_sum;

  logic [N-1:0]   op_data;
  logic [SW-1:0]  op_shift;
  logic [1:0]     op_mode;
  logic [IDW-1:0] id_r;

  logic [N-1:0]   sel_data;
  logic [SW-1:0]  sel_shift;
  logic [1:0]     sel_mode;

  // Rotating priority search starting at rr_ptr. The extra sum bit lets the
  // wrap be a single compare-and-subtract, which also works for non power-of-2 NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand_sum  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NREQ)) cand_sum = cand_sum - (IDW+1)'(NREQ);
      if (!grant_vld && req_valid[cand_sum[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant     = cand_sum[IDW-1:0];
      end
    end
  end

  // Pointer moves to the requester just after the winner.
  always_comb begin
    ptr_sum = {1'b0, grant} + (IDW+1)'(1);
    ptr_nxt = ptr_sum[IDW-1:0];
    if (ptr_sum >= (IDW+1)'(NREQ)) ptr_nxt = '0;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_data  = '0;
    sel_shift = '0;
    sel_mode  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_data  = req_data[i*N +: N];
        sel_shift = req_shift[i*SW +: SW];
        sel_mode  = req_mode[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant is only offered in IDLE and never while reset is asserted, so a
  // handshake can only complete when the FSM will actually take it.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld && !rst) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_nxt        = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      op_data   <= '0;
      op_shift  <= '0;
      op_mode   <= '0;
      id_r      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      if (accept) begin
        op_data  <= sel_data;
        op_shift <= sel_shift;
        op_mode  <= sel_mode;
        id_r     <= grant;
        rr_ptr   <= ptr_nxt;
      end
      if (state == EXEC) begin
        rsp_data  <= sh_out;
        rsp_id    <= id_r;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  assign sh_data  = op_data;
  assign sh_shift = op_shift;
  assign sh_mode  = op_mode;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed bench for barrel_shift_arbiter with a local combinational shifter model.
// Shifter modes here: 00 logical left, 01 logical right, 10 rotate left, 11 arithmetic right.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_barrel_shift_arbiter;

  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int SW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ*SW-1:0] req_shift;
  logic [NREQ*2-1:0] req_mode;
  logic [N-1:0]      sh_data;
  logic [SW-1:0]     sh_shift;
  logic [1:0]        sh_mode;
  logic [N-1:0]      sh_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  barrel_shift_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shift(req_shift), .req_mode(req_mode),
    .sh_data(sh_data), .sh_shift(sh_shift), .sh_mode(sh_mode), .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  logic [2*N-1:0] rot_tmp;
  always_comb begin
    rot_tmp = {sh_data, sh_data} << sh_shift;
    case (sh_mode)
      2'b00:   sh_out = sh_data << sh_shift;
      2'b01:   sh_out = sh_data >> sh_shift;
      2'b10:   sh_out = rot_tmp[2*N-1:N];
      default: sh_out = N'($signed(sh_data) >>> sh_shift);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] d, input logic [1:0] s,
                         input logic [1:0] m);
    req_data[i*N +: N]   = d;
    req_shift[i*SW +: SW] = s;
    req_mode[i*2 +: 2]   = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] rr_exp_data [4];
  int         prev_cyc;
  bit         found;

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    req_data  = '0;
    req_shift = '0;
    req_mode  = '0;

    // 1: reset state with every requester asking
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_sh", {sh_data, sh_shift, sh_mode}, 0);
    chk("rst_busy", busy, 0);
    rst       = 1'b0;
    req_valid = '0;

    // 2: single request from 2, rotate-left 1011 by 1 = 0111
    @(negedge clk);
    set_req(2, 4'b1011, 2'd1, 2'b10);
    req_valid = 4'b0100;
    #1 chk("single_grant", req_ready, 4'b0100);
    @(negedge clk);
    chk("single_exec_valid", rsp_valid, 0);
    chk("single_exec_busy", busy, 1);
    chk("single_exec_ready", req_ready, 0);
    chk("single_sh", {sh_data, sh_shift, sh_mode}, {4'b1011, 2'd1, 2'b10});
    req_valid = '0;
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_data", rsp_data, 4'b0111);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_done_valid", rsp_valid, 0);
    chk("single_done_busy", busy, 0);
    chk("single_hold_sh", sh_data, 4'b1011);

    // 4: wrap, rr_ptr=3 with 0 and 3 pending -> 3 then 0
    set_req(3, 4'b0001, 2'd2, 2'b00);
    set_req(0, 4'b1000, 2'd3, 2'b11);
    req_valid = 4'b1001;
    #1 chk("wrap_grant3", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("wrap_rsp3_id", rsp_id, 3);
    chk("wrap_rsp3_data", rsp_data, 4'b0100);
    @(negedge clk);
    chk("wrap_grant0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("wrap_rsp0_id", rsp_id, 0);
    chk("wrap_rsp0_data", rsp_data, 4'b1111);

    // 3: fresh pointer, all four held valid -> ids 0,1,2,3,0 every 3 cycles
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 4'b0001, 2'd1, 2'b00); rr_exp_data[0] = 4'b0010;
    set_req(1, 4'b1100, 2'd1, 2'b01); rr_exp_data[1] = 4'b0110;
    set_req(2, 4'b1011, 2'd1, 2'b10); rr_exp_data[2] = 4'b0111;
    set_req(3, 4'b1010, 2'd1, 2'b11); rr_exp_data[3] = 4'b1101;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    prev_cyc  = 0;
    for (int r = 0; r < 5; r++) begin
      found = 1'b0;
      for (int w = 0; w < 8 && !found; w++) begin
        @(negedge clk);
        if (rsp_valid) found = 1'b1;
      end
      if (!found) begin
        chk("rr_timeout", 0, 1);
      end else begin
        chk("rr_id", rsp_id, r % 4);
        chk("rr_data", rsp_data, rr_exp_data[r % 4]);
        if (r > 0) chk("rr_gap", cyc - prev_cyc, 3);
        prev_cyc = cyc;
      end
    end
    req_valid = '0;

    // 5: backpressure on a response from 1 (rr_ptr=1)
    @(negedge clk);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1 chk("bp_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 4'b0110);
      chk("bp_id", rsp_id, 1);
      chk("bp_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("bp_next_id", rsp_id, 0);
    chk("bp_next_data", rsp_data, 4'b0010);

    // 6: reset during EXEC drops the op; pointer restarts at 0 so 2 beats 3
    @(negedge clk);
    req_valid = 4'b0100;
    #1 chk("rx_grant", req_ready, 4'b0100);
    @(negedge clk);
    chk("rx_exec_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rx_busy", busy, 0);
    chk("rx_rsp_valid", rsp_valid, 0);
    chk("rx_ready_in_rst", req_ready, 0);
    chk("rx_sh_data", sh_data, 0);
    rst       = 1'b0;
    req_valid = 4'b1100;
    #1 chk("rx_regrant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("rx_rsp_valid2", rsp_valid, 1);
    chk("rx_rsp_id", rsp_id, 2);
    chk("rx_rsp_data", rsp_data, 4'b0111);
    @(negedge clk);
    chk("rx_next_grant", req_ready, 4'b1000);
    req_valid = '0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
